serv_rf_ram_if: RTL and testbench
=================================

SERV_RF_RAM_IF -- requirements
Module: serv_rf_ram_if

Interface
REQ-001 SHALL have parameter W, default 2, the RAM word width; legal values are 2, 4, 8, 16 and 32.
REQ-002 SHALL have derived parameter WPR = 32/W, the number of words per register; the RAM depth SHALL be 36*WPR and the address width AW = 6+log2(WPR).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_rreq, input, 1 bit: a one-cycle pulse that starts a 32-bit read of both read ports.
REQ-006 SHALL have ports i_rreg0 and i_rreg1, inputs, 6 bits each: the read register numbers (0-31 GPR, 32-35 CSR).
REQ-007 SHALL have port o_ready, output, 1 bit: a one-cycle pulse meaning serial read data starts on the next cycle.
REQ-008 SHALL have ports o_rdata0 and o_rdata1, outputs, 1 bit each: serial read data, LSB first.
REQ-009 SHALL have port i_wreq, input, 1 bit: a one-cycle pulse that starts a 32-bit serial write phase.
REQ-010 SHALL have ports i_wreg0 and i_wreg1, inputs, 6 bits each; ports i_wen0 and i_wen1, inputs, 1 bit each; and ports i_wdata0 and i_wdata1, inputs, 1 bit each: the serial write ports.
REQ-011 SHALL have port o_waddr, output, AW bits; port o_wdata, output, W bits; and port o_wen, output, 1 bit: the RAM write port.
REQ-012 SHALL have port o_raddr, output, AW bits; port o_ren, output, 1 bit; and port i_rdata, input, W bits: the RAM read port, which has a synchronous read with 1-cycle latency.

Function
REQ-013 RAM addresses SHALL be formed as {reg[5:0], word index}, where word index = k for the k-th W-bit slice of the register, starting from the LSB slice.
REQ-014 Read start: i_rreq sampled high at cycle R while the read side is idle SHALL latch i_rreg0 and i_rreg1 and mark the read side busy.
REQ-015 i_rreq sampled while the read side is busy SHALL be ignored.
REQ-016 RAM reads for k = 0..WPR-1: reg0 word k at cycle R+1+W*k, and reg1 word k at cycle R+2+W*k; o_ren SHALL be 1 only in those cycles.
REQ-017 o_ready SHALL be 1 only in cycle R+3.
REQ-018 o_rdata0/o_rdata1 SHALL carry bit n of reg0/reg1 in cycle R+4+n, for n = 0..31, and SHALL be 0 outside that window.
REQ-019 Each read port SHALL hold a current-word shift register plus a one-word prefetch buffer, so that no serial bit is lost when W = 2.
REQ-020 The read side SHALL be idle from cycle R+36; i_rreq sampled at R+35 or later SHALL be accepted.
REQ-021 Write start: i_wreq sampled high at cycle T while the write side is idle SHALL mark the write side busy; i_wreq sampled while it is busy SHALL be ignored.
REQ-022 i_wreg0, i_wreg1, i_wen0 and i_wen1 SHALL be latched at cycle T+1 and held for the whole phase.
REQ-023 Bit n of i_wdata0/i_wdata1 SHALL be sampled at cycle T+1+n, for n = 0..31.
REQ-024 Word k of each port SHALL be assembled LSB first from bits W*k .. W*k+W-1.
REQ-025 The port-0 word k SHALL be written at cycle T+W*(k+1)+1 if its latched wen0 = 1; the port-1 word k SHALL be written at cycle T+W*(k+1)+2 if its latched wen1 = 1; writes SHALL never collide.
REQ-026 o_wen SHALL be 1 only in write cycles; o_waddr and o_wdata SHALL be 0 when o_wen = 0.
REQ-027 The write side SHALL be idle from cycle T+35.
REQ-028 Read and write phases SHALL run fully independently and may overlap; no read-during-write forwarding SHALL be provided.
REQ-029 The block SHALL contain no storage for register contents beyond the shift and prefetch buffers.

Reset
REQ-030 i_rst_n = 0 SHALL immediately force both sides idle and clear all counters and buffers.
REQ-031 During reset, o_ready, o_ren, o_wen, o_rdata0, o_rdata1, o_raddr, o_waddr and o_wdata SHALL all be 0.
REQ-032 A read or write phase interrupted by reset SHALL be abandoned; no further RAM accesses SHALL occur, and the first i_rreq/i_wreq after release SHALL start a fresh phase.

Verification (W=2)
REQ-033 Reset: assert i_rst_n=0 mid-cycle -> every output is 0 asynchronously, before the next clock edge.
REQ-034 Read: RAM reg5=0xDEADBEEF, reg33=0x12345678; i_rreg0=5, i_rreg1=33, i_rreq at R -> o_raddr 80,528,81,529,...,95,543 at R+1..R+32; o_ready at R+3; 32 serial bits at R+4..R+35 equal the preloaded values.
REQ-035 Write: i_wreg0=3, i_wreg1=34, both wen=1, serial data 0xA5A5F00F and 0x00000001 -> 32 writes; first two are (48, 2'b11) at T+3 and (544, 2'b01) at T+4; RAM then holds both values.
REQ-036 Masked write: wen0=0, wen1=1 -> exactly 16 writes, all to the reg1 addresses, at cycles T+4+2k.
REQ-037 Overlap and ignore: i_wreq at cycle 0, i_rreq at cycle 5, second i_rreq at cycle 10 -> both phases complete with correct data; the second i_rreq produces no RAM reads.
REQ-038 Reset mid-read at R+10 -> o_ren drops immediately; a new i_rreq after release gives o_ready exactly 3 cycles later and the full correct serial data.

Source files
------------

// File: rtl/serv_rf_ram_if.sv
// Bit-serial register file front end: turns 1-bit read/write ports into
// W-bit accesses on a synchronous RAM holding 32 GPRs and 4 CSRs.
module serv_rf_ram_if #(
    parameter  int W   = 2,
    localparam int WPR = 32 / W,
    localparam int AW  = 6 + $clog2(WPR)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rreq,
    input  logic [5:0]    i_rreg0,
    input  logic [5:0]    i_rreg1,
    output logic          o_ready,
    output logic          o_rdata0,
    output logic          o_rdata1,
    input  logic          i_wreq,
    input  logic [5:0]    i_wreg0,
    input  logic [5:0]    i_wreg1,
    input  logic          i_wen0,
    input  logic          i_wen1,
    input  logic          i_wdata0,
    input  logic          i_wdata1,
    output logic [AW-1:0] o_waddr,
    output logic [W-1:0]  o_wdata,
    output logic          o_wen,
    output logic [AW-1:0] o_raddr,
    output logic          o_ren,
    input  logic [W-1:0]  i_rdata
);
    localparam int          LW   = $clog2(W);
    localparam int          IW   = AW - 6;
    localparam logic [5:0]  MSK  = 6'(W - 1);
    localparam logic [5:0]  LDPH = 6'(2 % W);

    // ---------------- read side ----------------
    logic         rbusy;
    logic [5:0]   rcnt;
    logic [5:0]   rreg0_q, rreg1_q;
    logic [W-1:0] rbuf0, rsh0, rsh1;
    logic [5:0]   rph;
    logic         rd_acc, rwin;

    assign rph    = rcnt & MSK;
    // The last serial cycle may already accept the next request.
    assign rd_acc = i_rreq && (!rbusy || rcnt == 6'd34);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rbusy   <= 1'b0;
            rcnt    <= '0;
            rreg0_q <= '0;
            rreg1_q <= '0;
            rbuf0   <= '0;
            rsh0    <= '0;
            rsh1    <= '0;
        end else begin
            if (rd_acc) begin
                rbusy   <= 1'b1;
                rcnt    <= '0;
                rreg0_q <= i_rreg0;
                rreg1_q <= i_rreg1;
            end else if (rbusy) begin
                if (rcnt == 6'd34) begin
                    rbusy <= 1'b0;
                    rcnt  <= '0;
                end else begin
                    rcnt <= rcnt + 6'd1;
                end
            end
            if (rbusy) begin
                // reg0 word lands one cycle before reg1's, so park it until both shift out together
                if (rph == 6'd1)
                    rbuf0 <= i_rdata;
                if (rph == LDPH && rcnt >= 6'd2) begin
                    rsh0 <= rbuf0;
                    rsh1 <= i_rdata;
                end else begin
                    rsh0 <= rsh0 >> 1;
                    rsh1 <= rsh1 >> 1;
                end
            end
        end
    end

    always_comb begin
        o_ren   = rbusy && rcnt < 6'd32 && (rph == 6'd0 || rph == 6'd1);
        o_raddr = '0;
        if (o_ren)
            o_raddr = (AW'(rph == 6'd0 ? rreg0_q : rreg1_q) << IW) | AW'(rcnt[4:0] >> LW);
        o_ready  = rbusy && rcnt == 6'd2;
        rwin     = rbusy && rcnt >= 6'd3 && rcnt <= 6'd34;
        o_rdata0 = rwin && rsh0[0];
        o_rdata1 = rwin && rsh1[0];
    end

    // ---------------- write side ----------------
    logic         wbusy;
    logic [5:0]   wcnt;
    logic [5:0]   wreg0_q, wreg1_q;
    logic         wen0_q, wen1_q;
    logic [W-1:0] wsh0, wsh1, wbuf1;
    logic [5:0]   wph;
    logic         wr0, wr1;
    logic [4:0]   widx0, widx1;

    assign wph = wcnt & MSK;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wbusy   <= 1'b0;
            wcnt    <= '0;
            wreg0_q <= '0;
            wreg1_q <= '0;
            wen0_q  <= 1'b0;
            wen1_q  <= 1'b0;
            wsh0    <= '0;
            wsh1    <= '0;
            wbuf1   <= '0;
        end else if (!wbusy) begin
            if (i_wreq) begin
                wbusy <= 1'b1;
                wcnt  <= '0;
            end
        end else begin
            if (wcnt == 6'd33) begin
                wbusy <= 1'b0;
                wcnt  <= '0;
            end else begin
                wcnt <= wcnt + 6'd1;
            end
            if (wcnt == 6'd0) begin
                wreg0_q <= i_wreg0;
                wreg1_q <= i_wreg1;
                wen0_q  <= i_wen0;
                wen1_q  <= i_wen1;
            end
            if (wcnt < 6'd32) begin
                wsh0 <= {i_wdata0, wsh0[W-1:1]};
                wsh1 <= {i_wdata1, wsh1[W-1:1]};
            end
            // port 1 writes a cycle after port 0, by which time its shifter has moved on
            if (wph == 6'd0 && wcnt >= 6'(W))
                wbuf1 <= wsh1;
        end
    end

    always_comb begin
        widx0   = 5'(wcnt >> LW) - 5'd1;
        widx1   = 5'((wcnt - 6'd1) >> LW) - 5'd1;
        wr0     = wbusy && wen0_q && wph == 6'd0 && wcnt >= 6'(W) && wcnt <= 6'd32;
        wr1     = wbusy && wen1_q && wph == 6'd1 && wcnt >= 6'(W + 1) && wcnt <= 6'd33;
        o_wen   = wr0 || wr1;
        o_waddr = '0;
        o_wdata = '0;
        if (wr0) begin
            o_waddr = (AW'(wreg0_q) << IW) | AW'(widx0);
            o_wdata = wsh0;
        end else if (wr1) begin
            o_waddr = (AW'(wreg1_q) << IW) | AW'(widx1);
            o_wdata = wbuf1;
        end
    end
endmodule

// File: tb/tb_serv_rf_ram_if.sv
// Scoreboard bench for serv_rf_ram_if at W=2: stimulus pushes expected RAM
// accesses and serial bits, a negedge monitor pops and compares.
module tb_serv_rf_ram_if;
    localparam int W  = 2;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_rreq = 1'b0, i_wreq = 1'b0;
    logic [5:0]    i_rreg0 = '0, i_rreg1 = '0, i_wreg0 = '0, i_wreg1 = '0;
    logic          i_wen0 = 1'b0, i_wen1 = 1'b0, i_wdata0 = 1'b0, i_wdata1 = 1'b0;
    logic          o_ready, o_rdata0, o_rdata1, o_wen, o_ren;
    logic [AW-1:0] o_waddr, o_raddr;
    logic [W-1:0]  o_wdata;
    logic [W-1:0]  i_rdata = '0;

    serv_rf_ram_if #(.W(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rreq(i_rreq), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
        .o_ready(o_ready), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .i_wreq(i_wreq), .i_wreg0(i_wreg0), .i_wreg1(i_wreg1),
        .i_wen0(i_wen0), .i_wen1(i_wen1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
        .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous read, one cycle latency
    logic [1:0] mem [0:575];
    always @(posedge clk) begin
        if (o_ren) i_rdata <= mem[o_raddr];
        if (o_wen) mem[o_waddr] = o_wdata;
    end

    typedef struct { int cyc; int addr; int data; } wev_t;
    typedef struct { int cyc; int addr; } rev_t;
    typedef struct { int cyc; logic b0; logic b1; } bev_t;
    wev_t wq[$];
    rev_t rq[$];
    int   readyq[$];
    bev_t bq[$];

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h expected no activity (cycle %0d)", nm, act, cyc);
    endtask

    always @(negedge clk) begin
        wev_t we;
        rev_t re;
        bev_t be;
        if (o_wen) begin
            if (wq.size() == 0) flag("unexpected_write", int'(o_waddr));
            else begin
                we = wq.pop_front();
                chk("wr_cycle", cyc, we.cyc);
                chk("wr_addr", int'(o_waddr), we.addr);
                chk("wr_data", int'(o_wdata), we.data);
            end
        end else if (o_waddr != '0 || o_wdata != '0)
            flag("wport_idle_nonzero", int'({o_waddr, o_wdata}));
        if (o_ren) begin
            if (rq.size() == 0) flag("unexpected_read", int'(o_raddr));
            else begin
                re = rq.pop_front();
                chk("rd_cycle", cyc, re.cyc);
                chk("rd_addr", int'(o_raddr), re.addr);
            end
        end
        if (o_ready) begin
            if (readyq.size() == 0) flag("unexpected_ready", 1);
            else chk("ready_cycle", cyc, readyq.pop_front());
        end
        if (bq.size() > 0 && bq[0].cyc == cyc) begin
            be = bq.pop_front();
            chk("rdata0", int'(o_rdata0), int'(be.b0));
            chk("rdata1", int'(o_rdata1), int'(be.b1));
        end else if (o_rdata0 || o_rdata1)
            flag("rdata_outside_window", int'({o_rdata1, o_rdata0}));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input int r, input logic [31:0] v);
        for (int k = 0; k < 16; k++) mem[10'(r * 16 + k)] = v[2*k +: 2];
    endtask

    function automatic logic [31:0] reg_val(input int r);
        logic [31:0] v;
        for (int k = 0; k < 16; k++) v[2*k +: 2] = mem[10'(r * 16 + k)];
        return v;
    endfunction

    task automatic do_read(input int r0, input int r1, input logic [31:0] v0,
                           input logic [31:0] v1, input bit acc);
        int r;
        r = cyc;
        i_rreg0 = 6'(r0);
        i_rreg1 = 6'(r1);
        i_rreq  = 1'b1;
        if (acc) begin
            for (int k = 0; k < 16; k++) begin
                rq.push_back('{r + 1 + 2*k, r0 * 16 + k});
                rq.push_back('{r + 2 + 2*k, r1 * 16 + k});
            end
            readyq.push_back(r + 3);
            for (int n = 0; n < 32; n++) bq.push_back('{r + 4 + n, v0[n], v1[n]});
        end
        step();
        i_rreq = 1'b0;
    endtask

    task automatic do_write(input int r0, input int r1, input bit e0, input bit e1,
                            input logic [31:0] d0, input logic [31:0] d1);
        int t;
        t = cyc;
        i_wreq = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (e0) wq.push_back('{t + 3 + 2*k, r0 * 16 + k, int'(d0[2*k +: 2])});
            if (e1) wq.push_back('{t + 4 + 2*k, r1 * 16 + k, int'(d1[2*k +: 2])});
        end
        step();
        i_wreq  = 1'b0;
        i_wreg0 = 6'(r0);
        i_wreg1 = 6'(r1);
        i_wen0  = e0;
        i_wen1  = e1;
        for (int n = 0; n < 32; n++) begin
            i_wdata0 = d0[n];
            i_wdata1 = d1[n];
            step();
        end
        {i_wdata0, i_wdata1, i_wen0, i_wen1} = '0;
        i_wreg0 = '0;
        i_wreg1 = '0;
    endtask

    function automatic int all_outs();
        return int'({o_ready, o_ren, o_wen, o_rdata0, o_rdata1, o_raddr, o_waddr, o_wdata});
    endfunction

    initial begin
        for (int a = 0; a < 576; a++) mem[a] = '0;
        load_reg(5, 32'hDEADBEEF);
        load_reg(33, 32'h12345678);
        load_reg(10, 32'hCAFEF00D);
        repeat (2) @(posedge clk);
        #3 chk("outputs_in_reset", all_outs(), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step();

        // plain read of a GPR and a CSR
        do_read(5, 33, 32'hDEADBEEF, 32'h12345678, 1'b1);
        repeat (40) step();

        // full write on both ports, then read back
        do_write(3, 34, 1'b1, 1'b1, 32'hA5A5F00F, 32'h00000001);
        repeat (4) step();
        chk("ram_reg3", int'(reg_val(3)), 32'hA5A5F00F);
        chk("ram_reg34", int'(reg_val(34)), 32'h00000001);
        do_read(3, 34, 32'hA5A5F00F, 32'h00000001, 1'b1);
        repeat (40) step();

        // port 0 masked: reg10 must keep its old value
        do_write(10, 11, 1'b0, 1'b1, 32'hFFFF0000, 32'h0F0F1234);
        repeat (4) step();
        do_read(10, 11, 32'hCAFEF00D, 32'h0F0F1234, 1'b1);
        repeat (40) step();

        // overlapping write and read; second read request while busy is dropped
        fork
            do_write(7, 8, 1'b1, 1'b1, 32'h13579BDF, 32'h2468ACE0);
            begin
                repeat (5) step();
                do_read(5, 33, 32'hDEADBEEF, 32'h12345678, 1'b1);
                repeat (4) step();
                do_read(3, 34, 32'h0, 32'h0, 1'b0);
            end
        join
        repeat (10) step();
        do_read(7, 8, 32'h13579BDF, 32'h2468ACE0, 1'b1);
        repeat (40) step();

        // reset in the middle of a read
        do_read(5, 33, 32'hDEADBEEF, 32'h12345678, 1'b1);
        repeat (9) step();
        #2 chk("ren_before_reset", int'(o_ren), 1);
        rst_n = 1'b0;
        rq.delete();
        readyq.delete();
        bq.delete();
        #1 chk("outputs_async_reset", all_outs(), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        do_read(5, 33, 32'hDEADBEEF, 32'h12345678, 1'b1);
        repeat (40) step();

        chk("pending_writes", wq.size(), 0);
        chk("pending_reads", rq.size(), 0);
        chk("pending_ready", readyq.size(), 0);
        chk("pending_bits", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
